// File: rtl/axi_lite_cfg_regfile.sv
// AXI-lite configuration register slave behind crossbar port 0: ID, scratch, control,
// interrupt and error registers, with held AW/W halves, a read FIFO and counted write responses.
module axi_lite_cfg_regfile #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          NREGS    = 16,
  parameter int          RQ_DEPTH = 4,
  parameter int          BQ_DEPTH = 4,
  parameter logic [31:0] ID_VALUE = 32'hB1AC_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_awvalid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic              s_arvalid,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] ctrl_o,
  input  logic [DATA_W-1:0] irq_set_i,
  output logic              irq_o
);

  localparam int OFF_W = $clog2(NREGS);
  localparam int RQ_AW = $clog2(RQ_DEPTH);
  localparam int RC_W  = $clog2(RQ_DEPTH + 1);
  localparam int BC_W  = $clog2(BQ_DEPTH + 1);

  localparam logic [OFF_W-1:0] OFF_ID   = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_CTRL = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_STAT = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_MASK = OFF_W'(4);
  localparam logic [OFF_W-1:0] OFF_ERR  = OFF_W'(5);
  localparam logic [RC_W-1:0]  RQ_FULL  = RC_W'(RQ_DEPTH);
  localparam logic [BC_W-1:0]  B_FULL   = BC_W'(BQ_DEPTH);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] irq_status;
  logic [15:0]       err_cnt;
  logic              b_ovf, rq_ovf, aw_ovf;
  logic              aw_hold_v, w_hold_v;
  logic [ADDR_W-1:0] aw_hold_addr;
  logic [DATA_W-1:0] w_hold_data;
  logic [BC_W-1:0]   b_cnt;
  logic [ADDR_W-1:0] rq_mem [RQ_DEPTH];
  logic [RQ_AW-1:0]  rq_wr_ptr, rq_rd_ptr;
  logic [RC_W-1:0]   rq_cnt;

  logic              commit, wr_ok, b_hs, rq_pop, rq_push, rq_full, rd_ok;
  logic              err_clr, err_inc, b_drop, rq_drop, hold_ovf;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_value, err_view, w1c;
  logic [OFF_W-1:0]  wr_off, rd_off;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (OFF_W + 2)) == '0);
  endfunction

  // A held half always belongs to an older request than a pulse arriving now.
  assign commit  = (aw_hold_v || s_awvalid) && (w_hold_v || s_wvalid);
  assign wr_addr = aw_hold_v ? aw_hold_addr : s_awaddr;
  assign wr_data = w_hold_v ? w_hold_data : s_wdata;
  assign wr_off  = wr_addr[OFF_W+1:2];
  assign wr_ok   = addr_ok(wr_addr);

  assign s_bvalid = (b_cnt != '0);
  assign b_hs     = s_bvalid && s_bready;
  assign b_drop   = commit && !b_hs && (b_cnt == B_FULL);

  assign rq_full  = (rq_cnt == RQ_FULL);
  assign rq_pop   = (rq_cnt != '0) && !commit;
  assign rq_push  = s_arvalid && (!rq_full || rq_pop);
  assign rq_drop  = s_arvalid && rq_full && !rq_pop;
  assign rd_addr  = rq_mem[rq_rd_ptr];
  assign rd_off   = rd_addr[OFF_W+1:2];
  assign rd_ok    = addr_ok(rd_addr);

  assign hold_ovf = !commit && ((s_awvalid && aw_hold_v) || (s_wvalid && w_hold_v));
  assign err_clr  = commit && wr_ok && (wr_off == OFF_ERR);
  assign err_inc  = (commit && !wr_ok) || (rq_pop && !rd_ok);
  assign w1c      = (commit && wr_ok && (wr_off == OFF_STAT)) ? wr_data : '0;
  assign err_view = {{(DATA_W-19){1'b0}}, aw_ovf, rq_ovf, b_ovf, err_cnt};
  assign ctrl_o   = regs[OFF_CTRL];

  always_comb begin
    rd_value = 32'hDEAD_BEEF;
    if (rd_ok) begin
      case (rd_off)
        OFF_ID:   rd_value = ID_VALUE;
        OFF_STAT: rd_value = irq_status;
        OFF_ERR:  rd_value = err_view;
        default:  rd_value = regs[rd_off];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_hold_v    <= 1'b0;
      w_hold_v     <= 1'b0;
      aw_hold_addr <= '0;
      w_hold_data  <= '0;
    end else begin
      aw_hold_v <= commit ? (aw_hold_v && s_awvalid) : (aw_hold_v || s_awvalid);
      w_hold_v  <= commit ? (w_hold_v && s_wvalid) : (w_hold_v || s_wvalid);
      if (s_awvalid) aw_hold_addr <= s_awaddr;
      if (s_wvalid)  w_hold_data  <= s_wdata;
    end
  end

  // ID, IRQ_STATUS and ERR live outside the plain storage array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok && (wr_off != OFF_ID) && (wr_off != OFF_STAT) && (wr_off != OFF_ERR)) begin
      regs[wr_off] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_status <= '0;
      irq_o      <= 1'b0;
      err_cnt    <= '0;
      b_ovf      <= 1'b0;
      rq_ovf     <= 1'b0;
      aw_ovf     <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~w1c) | irq_set_i;
      irq_o      <= |(irq_status & regs[OFF_MASK]);
      if (err_clr)
        err_cnt <= err_inc ? 16'd1 : 16'd0;
      else if (err_inc && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      b_ovf  <= (b_ovf && !err_clr) || b_drop;
      rq_ovf <= (rq_ovf && !err_clr) || rq_drop;
      aw_ovf <= (aw_ovf && !err_clr) || hold_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_cnt <= '0;
    end else begin
      case ({commit, b_hs})
        2'b10:   if (!b_drop) b_cnt <= b_cnt + BC_W'(1);
        2'b01:   b_cnt <= b_cnt - BC_W'(1);
        default: b_cnt <= b_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wr_ptr] <= s_araddr;
  end

  // Pop reads the slot before any same-edge push can overwrite it when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq_wr_ptr <= '0;
      rq_rd_ptr <= '0;
      rq_cnt    <= '0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
    end else begin
      if (rq_push) rq_wr_ptr <= rq_wr_ptr + RQ_AW'(1);
      if (rq_pop)  rq_rd_ptr <= rq_rd_ptr + RQ_AW'(1);
      case ({rq_push, rq_pop})
        2'b10:   rq_cnt <= rq_cnt + RC_W'(1);
        2'b01:   rq_cnt <= rq_cnt - RC_W'(1);
        default: rq_cnt <= rq_cnt;
      endcase
      s_rvalid <= rq_pop;
      if (rq_pop) s_rdata <= rd_value;
    end
  end

endmodule

// File: tb/tb_axi_lite_cfg_regfile.sv
// Self-checking bench for axi_lite_cfg_regfile: directed sequences, a vector table and
// randomized traffic, all compared every cycle against a queue-based behavioural model.
module tb_axi_lite_cfg_regfile;
  localparam int NREGS = 16, RQ_DEPTH = 4, BQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0, s_bready = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, irq_set_i = '0;
  logic        s_bvalid, s_rvalid, irq_o;
  logic [31:0] s_rdata, ctrl_o;

  int n_checks = 0, n_fail = 0;

  axi_lite_cfg_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .ctrl_o(ctrl_o), .irq_set_i(irq_set_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain register array, integer counters and a request queue.
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_status, m_rdata, m_aw_a, m_w_d;
  logic [31:0] m_rq [$];
  int          m_err, m_bcnt;
  bit          m_bovf, m_rqovf, m_awovf, m_aw_v, m_w_v, m_rvalid, m_irq;

  function automatic bit m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(NREGS * 4));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_ok(a)) return 32'hDEAD_BEEF;
    case (a / 4)
      0:       return 32'hB1AC_0001;
      3:       return m_status;
      5:       return {13'd0, m_awovf, m_rqovf, m_bovf, 16'(m_err)};
      default: return m_regs[a / 4];
    endcase
  endfunction

  task automatic model_step();
    bit commit, hs, pop, e_inc, e_clr, set_b, set_rq, set_aw, irq_next;
    logic [31:0] ca, cd, w1c;
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_status = '0; m_rdata = '0; m_err = 0; m_bcnt = 0;
      m_bovf = 0; m_rqovf = 0; m_awovf = 0; m_aw_v = 0; m_w_v = 0;
      m_rvalid = 0; m_irq = 0;
      m_rq.delete();
      return;
    end
    commit = (m_aw_v || s_awvalid) && (m_w_v || s_wvalid);
    ca = m_aw_v ? m_aw_a : s_awaddr;
    cd = m_w_v ? m_w_d : s_wdata;
    hs = (m_bcnt > 0) && s_bready;
    pop = (m_rq.size() > 0) && !commit;
    irq_next = (m_status & m_regs[4]) != 0;
    e_inc = 0; e_clr = 0; set_b = 0; set_rq = 0; set_aw = 0; w1c = '0;
    m_rvalid = pop;
    if (pop) begin
      m_rdata = m_read(m_rq[0]);
      if (!m_ok(m_rq[0])) e_inc = 1;
      void'(m_rq.pop_front());
    end
    if (commit) begin
      if (!m_ok(ca)) e_inc = 1;
      else case (ca / 4)
        0: ;
        3: w1c = cd;
        5: e_clr = 1;
        default: m_regs[ca / 4] = cd;
      endcase
      if (!hs) begin
        if (m_bcnt == BQ_DEPTH) set_b = 1;
        else m_bcnt++;
      end
      m_aw_v = m_aw_v && s_awvalid;
      m_w_v  = m_w_v && s_wvalid;
    end else begin
      if (hs) m_bcnt--;
      if ((s_awvalid && m_aw_v) || (s_wvalid && m_w_v)) set_aw = 1;
      m_aw_v = m_aw_v || s_awvalid;
      m_w_v  = m_w_v || s_wvalid;
    end
    if (s_awvalid) m_aw_a = s_awaddr;
    if (s_wvalid)  m_w_d  = s_wdata;
    if (s_arvalid) begin
      if (m_rq.size() < RQ_DEPTH) m_rq.push_back(s_araddr);
      else set_rq = 1;
    end
    if (e_clr) begin m_err = 0; m_bovf = 0; m_rqovf = 0; m_awovf = 0; end
    if (e_inc && m_err < 65535) m_err++;
    m_bovf  = m_bovf || set_b;
    m_rqovf = m_rqovf || set_rq;
    m_awovf = m_awovf || set_aw;
    m_status = (m_status & ~w1c) | irq_set_i;
    m_irq = irq_next;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic [31:0] awa, input logic w, input logic [31:0] wd,
                               input logic ar, input logic [31:0] ara, input logic [31:0] irq);
    s_awvalid = aw; s_awaddr = awa; s_wvalid = w; s_wdata = wd;
    s_arvalid = ar; s_araddr = ara; irq_set_i = irq;
  endtask

  // One clock: advance the model with the driven inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    checkOutput("bvalid", 32'(s_bvalid), 32'(m_bcnt != 0));
    checkOutput("rvalid", 32'(s_rvalid), 32'(m_rvalid));
    if (m_rvalid) checkOutput("rdata", s_rdata, m_rdata);
    checkOutput("ctrl_o", ctrl_o, m_regs[2]);
    checkOutput("irq_o", 32'(irq_o), 32'(m_irq));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, 1'b1, d, 1'b0, '0, '0);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int waited;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, a, '0);
    tick();
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!s_rvalid && waited < 8);
    checkOutput("rd_latency", 32'(waited), 32'd1);
    d = s_rdata;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rd, got_data [4];
  logic [31:0] rd_addrs [6];
  logic [31:0] pool [12];
  int          got;

  initial begin
    vecs[0] = '{1'b1, 32'h04, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 32'hB1AC_0001};
    vecs[2] = '{1'b1, 32'h08, 32'h0000_00A5, 32'h0000_00A5};
    vecs[3] = '{1'b1, 32'h3C, 32'hDEAD_0000, 32'hDEAD_0000};
    vecs[4] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 32'h02, 32'h0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 32'h14, 32'h1234, 32'h0};
    rd_addrs = '{32'h00, 32'h2C, 32'h08, 32'h1C, 32'h20, 32'h24};
    pool = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h3C,
             32'h40, 32'h02, 32'h1000_0000, 32'h41};

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checkOutput("rst_rdata", s_rdata, 32'h0);
    checkOutput("rst_ctrl", ctrl_o, 32'h0);

    do_read(32'h00, rd); checkOutput("id_read", rd, 32'hB1AC_0001);
    do_read(32'h08, rd); checkOutput("ctrl_read", rd, 32'h0);
    do_read(32'h14, rd); checkOutput("err_read", rd, 32'h0);

    // Split AW/W: address first, data three cycles later.
    applyStimulus(1'b1, 32'h04, 1'b0, '0, 1'b0, '0, '0);
    tick();
    repeat (2) begin tick(); checkOutput("no_early_commit", 32'(s_bvalid), 32'd0); end
    applyStimulus(1'b0, '0, 1'b1, 32'hCAFE_F00D, 1'b0, '0, '0);
    tick();
    checkOutput("bvalid_after_w", 32'(s_bvalid), 32'd1);
    do_read(32'h04, rd); checkOutput("split_write", rd, 32'hCAFE_F00D);

    // Response queue overflow with bready held low.
    s_bready = 1'b0;
    for (int i = 0; i < 5; i++) do_write(32'h18 + 32'(4 * i), 32'h1000 + 32'(i));
    checkOutput("bvalid_full", 32'(s_bvalid), 32'd1);
    do_read(32'h14, rd); checkOutput("err_b_ovf", rd, 32'h0001_0000);
    do_read(32'h28, rd); checkOutput("fifth_write", rd, 32'h1004);
    for (int i = 0; i < 4; i++) begin
      s_bready = 1'b1; tick(); s_bready = 1'b0;
      checkOutput("b_drain", 32'(s_bvalid), (i == 3) ? 32'd0 : 32'd1);
    end
    s_bready = 1'b1;
    do_write(32'h14, 32'h0);
    do_read(32'h14, rd); checkOutput("err_clear", rd, 32'h0);

    // Interrupts: set beats a same-cycle W1C.
    do_write(32'h10, 32'h1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 32'h1);
    tick(); tick();
    checkOutput("irq_on", 32'(irq_o), 32'd1);
    applyStimulus(1'b1, 32'h0C, 1'b1, 32'h1, 1'b0, '0, 32'h1);
    repeat (3) tick();
    checkOutput("irq_set_wins", 32'(irq_o), 32'd1);
    do_read(32'h0C, rd); checkOutput("status_kept", rd, 32'h1);
    do_write(32'h0C, 32'h1);
    tick(); tick();
    checkOutput("irq_cleared", 32'(irq_o), 32'd0);

    // Writes starve the read FIFO; two reads overflow and are dropped.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h2C, 1'b1, 32'h600 + 32'(i), 1'b1, rd_addrs[i], '0);
      tick();
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rvalid && got < 4) begin got_data[got] = s_rdata; got++; end
    end
    checkOutput("rq_returned", 32'(got), 32'd4);
    checkOutput("rq_order0", got_data[0], 32'hB1AC_0001);
    checkOutput("rq_order1", got_data[1], 32'h605);
    checkOutput("rq_order2", got_data[2], 32'h0);
    checkOutput("rq_order3", got_data[3], 32'h1001);
    do_read(32'h14, rd); checkOutput("err_rq_ovf", rd, 32'h0002_0000);

    // Invalid accesses.
    do_write(32'h14, 32'h0);
    do_read(32'h40, rd); checkOutput("bad_range", rd, 32'hDEAD_BEEF);
    do_read(32'h05, rd); checkOutput("bad_align", rd, 32'hDEAD_BEEF);
    do_read(32'h14, rd); checkOutput("err_count2", rd, 32'h0000_0002);
    do_write(32'h14, 32'h0);
    do_read(32'h14, rd); checkOutput("err_count0", rd, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      do_read(vecs[i].addr, rd);
      checkOutput($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      s_bready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 9) < 3, pool[$urandom_range(0, 11)],
                    $urandom_range(0, 9) < 3, $urandom,
                    $urandom_range(0, 9) < 3, pool[$urandom_range(0, 11)],
                    ($urandom_range(0, 7) == 0) ? $urandom : 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
